// File: rtl/mcycle_control_pkg.sv
// Shared types and instruction encodings for the multi-cycle controller.
// Opcodes/functions not listed here decode as NOPs.
package codes;

   typedef logic [5:0] opcode_t;
   typedef logic [5:0] func_t;

   typedef enum logic [1:0] {FETCH, EXEC1, EXEC2, HALTED} state_t;
   typedef enum logic {PC_SEL_INC, PC_SEL_TARGET} pc_sel_t;
   typedef enum logic [1:0] {WDATA_ALU, WDATA_RAM, WDATA_LINK} wdata_sel_t;
   typedef enum logic [1:0] {RT, RD, RA31} regfile_addr_sel_t;

   localparam opcode_t OP_SPECIAL = 6'h00;
   localparam opcode_t OP_REGIMM  = 6'h01;
   localparam opcode_t OP_J       = 6'h02;
   localparam opcode_t OP_JAL     = 6'h03;
   localparam opcode_t OP_BEQ     = 6'h04;
   localparam opcode_t OP_BNE     = 6'h05;
   localparam opcode_t OP_ADDIU   = 6'h09;
   localparam opcode_t OP_LW      = 6'h23;
   localparam opcode_t OP_SW      = 6'h2B;

   localparam func_t FN_JR   = 6'h08;
   localparam func_t FN_JALR = 6'h09;
   localparam func_t FN_ADDU = 6'h21;

   localparam logic [4:0] RT_BLTZ = 5'h00;
   localparam logic [4:0] RT_BGEZ = 5'h01;

endpackage

// File: rtl/mcycle_decode.sv
// Combinational output decode for the multi-cycle controller: enables and
// selects from state, IR fields, the delay-slot flag and memory stall.
module mcycle_decode
   import codes::*;
#(
   parameter bit WAITREQ_EN    = 1'b1,
   parameter bit DELAY_SLOT_EN = 1'b1
) (
   input  logic              reset_i,
   input  state_t            state_i,
   input  opcode_t           opcode_i,
   input  func_t             function_i,
   input  logic [4:0]        rt_i,
   input  logic              ram_waitrequest_i,
   input  logic              branch_cond_i,
   input  logic              delay_pending_i,
   output logic              stall_o,
   output logic              active_o,
   output logic              pc_write_en_o,
   output logic              ir_write_en_o,
   output logic              ram_read_en_o,
   output logic              ram_write_en_o,
   output logic              src_b_sel_o,
   output logic              ram_addr_sel_o,
   output logic              regfile_write_en_o,
   output logic              target_write_en_o,
   output pc_sel_t           pc_sel_o,
   output wdata_sel_t        regfile_writedata_sel_o,
   output regfile_addr_sel_t regfile_addr_3_sel_o
);

   logic isLw, isSw, ramAccess;

   always_comb begin
      isLw      = (opcode_i == OP_LW);
      isSw      = (opcode_i == OP_SW);
      ramAccess = (state_i == FETCH) || ((state_i == EXEC1) && isLw) ||
                  ((state_i == EXEC2) && isSw);
      stall_o   = WAITREQ_EN && ram_waitrequest_i && ramAccess;
      active_o  = (state_i != HALTED);
   end

   always_comb begin
      pc_write_en_o           = 1'b0;
      ir_write_en_o           = 1'b0;
      ram_read_en_o           = 1'b0;
      ram_write_en_o          = 1'b0;
      src_b_sel_o             = 1'b0;
      ram_addr_sel_o          = 1'b0;
      regfile_write_en_o      = 1'b0;
      target_write_en_o       = 1'b0;
      pc_sel_o                = PC_SEL_INC;
      regfile_writedata_sel_o = WDATA_ALU;
      regfile_addr_3_sel_o    = RT;
      case (state_i)
         FETCH: ram_read_en_o = 1'b1;
         EXEC1: begin
            ir_write_en_o = 1'b1;
            if (isLw) begin
               ram_read_en_o  = 1'b1;
               src_b_sel_o    = 1'b1;
               ram_addr_sel_o = 1'b1;
            end
         end
         EXEC2: begin
            pc_write_en_o = 1'b1;
            case (opcode_i)
               OP_LW: begin
                  regfile_write_en_o      = 1'b1;
                  regfile_writedata_sel_o = WDATA_RAM;
               end
               OP_SW: begin
                  ram_write_en_o = 1'b1;
                  src_b_sel_o    = 1'b1;
                  ram_addr_sel_o = 1'b1;
               end
               OP_ADDIU: begin
                  regfile_write_en_o = 1'b1;
                  src_b_sel_o        = 1'b1;
               end
               OP_SPECIAL: begin
                  case (function_i)
                     FN_ADDU: begin
                        regfile_write_en_o   = 1'b1;
                        regfile_addr_3_sel_o = RD;
                     end
                     FN_JR: target_write_en_o = 1'b1;
                     FN_JALR: begin
                        target_write_en_o       = 1'b1;
                        regfile_write_en_o      = 1'b1;
                        regfile_writedata_sel_o = WDATA_LINK;
                        regfile_addr_3_sel_o    = RD;
                     end
                     default: ;
                  endcase
               end
               OP_REGIMM: begin
                  if ((rt_i == RT_BLTZ) || (rt_i == RT_BGEZ))
                     target_write_en_o = branch_cond_i;
               end
               OP_BEQ, OP_BNE: target_write_en_o = branch_cond_i;
               OP_J: target_write_en_o = 1'b1;
               OP_JAL: begin
                  target_write_en_o       = 1'b1;
                  regfile_write_en_o      = 1'b1;
                  regfile_writedata_sel_o = WDATA_LINK;
                  regfile_addr_3_sel_o    = RA31;
               end
               default: ;
            endcase
            // With a delay slot the PC follows the older pending target, never this one
            if (DELAY_SLOT_EN) begin
               if (delay_pending_i) pc_sel_o = PC_SEL_TARGET;
            end else if (target_write_en_o) begin
               pc_sel_o = PC_SEL_TARGET;
            end
         end
         default: ;
      endcase
      if (stall_o || reset_i) begin
         pc_write_en_o      = 1'b0;
         ir_write_en_o      = 1'b0;
         ram_write_en_o     = 1'b0;
         regfile_write_en_o = 1'b0;
         target_write_en_o  = 1'b0;
      end
      if (reset_i) ram_read_en_o = 1'b0;
   end

endmodule

// File: rtl/mcycle_control.sv
// Multi-cycle CPU controller: state register, delay-slot flag and saturating
// retired-instruction counter around the combinational decode.
module mcycle_control
   import codes::*;
#(
   parameter bit          WAITREQ_EN    = 1'b1,
   parameter bit          DELAY_SLOT_EN = 1'b1,
   parameter int unsigned RETIRE_W      = 32
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  opcode_t             opcode_i,
   input  func_t               function_i,
   input  logic [4:0]          rt_i,
   input  logic                ram_waitrequest_i,
   input  logic                branch_cond_i,
   input  logic                pc_next_zero_i,
   output state_t              state_o,
   output logic                active_o,
   output logic                pc_write_en_o,
   output logic                ir_write_en_o,
   output logic                ram_read_en_o,
   output logic                ram_write_en_o,
   output logic                src_b_sel_o,
   output logic                ram_addr_sel_o,
   output logic                regfile_write_en_o,
   output logic                target_write_en_o,
   output pc_sel_t             pc_sel_o,
   output wdata_sel_t          regfile_writedata_sel_o,
   output regfile_addr_sel_t   regfile_addr_3_sel_o,
   output logic [RETIRE_W-1:0] retired_o
);

   state_t              state_q, state_d;
   logic                delay_pending_q, delay_pending_d;
   logic [RETIRE_W-1:0] retired_q, retired_d;
   logic                stall;

   mcycle_decode #(
      .WAITREQ_EN    (WAITREQ_EN),
      .DELAY_SLOT_EN (DELAY_SLOT_EN)
   ) u_decode (
      .reset_i                 (reset_i),
      .state_i                 (state_q),
      .opcode_i                (opcode_i),
      .function_i              (function_i),
      .rt_i                    (rt_i),
      .ram_waitrequest_i       (ram_waitrequest_i),
      .branch_cond_i           (branch_cond_i),
      .delay_pending_i         (delay_pending_q),
      .stall_o                 (stall),
      .active_o                (active_o),
      .pc_write_en_o           (pc_write_en_o),
      .ir_write_en_o           (ir_write_en_o),
      .ram_read_en_o           (ram_read_en_o),
      .ram_write_en_o          (ram_write_en_o),
      .src_b_sel_o             (src_b_sel_o),
      .ram_addr_sel_o          (ram_addr_sel_o),
      .regfile_write_en_o      (regfile_write_en_o),
      .target_write_en_o       (target_write_en_o),
      .pc_sel_o                (pc_sel_o),
      .regfile_writedata_sel_o (regfile_writedata_sel_o),
      .regfile_addr_3_sel_o    (regfile_addr_3_sel_o)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q         <= FETCH;
         delay_pending_q <= 1'b0;
         retired_q       <= '0;
      end else begin
         state_q         <= state_d;
         delay_pending_q <= delay_pending_d;
         retired_q       <= retired_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      delay_pending_d = delay_pending_q;
      retired_d       = retired_q;
      case (state_q)
         FETCH: if (!stall) state_d = EXEC1;
         EXEC1: if (!stall) state_d = EXEC2;
         EXEC2: begin
            if (!stall) begin
               state_d = (pc_write_en_o && pc_next_zero_i) ? HALTED : FETCH;
               // Each retiring instruction either consumes or re-arms the pending redirect
               delay_pending_d = DELAY_SLOT_EN && target_write_en_o;
               if (retired_q != {RETIRE_W{1'b1}}) retired_d = retired_q + RETIRE_W'(1);
            end
         end
         default: state_d = HALTED;
      endcase
   end

   assign state_o   = state_q;
   assign retired_o = retired_q;

endmodule
